// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet router: flit payload, FIFO entry and per-VC state.
package chiplet_types_pkg;

  localparam int unsigned NODE_ID_W = 4;
  localparam int unsigned PKT_ID_W  = 8;
  localparam int unsigned PAYLOAD_W = 16;

  typedef logic [NODE_ID_W-1:0] node_id_t;
  typedef logic [PKT_ID_W-1:0]  pkt_id_t;

  typedef struct packed {
    node_id_t              dst;
    node_id_t              src;
    pkt_id_t               pkt_id;
    logic [PAYLOAD_W-1:0]  payload;
  } flit_t;

  // One buffered slot: the flit plus its packet-tail marker.
  typedef struct packed {
    logic  last;
    flit_t flit;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTING = 2'd1,
    ACTIVE  = 2'd2
  } vc_state_t;

endpackage

// File: rtl/vc_fifo.sv
// Circular flit buffer for one virtual channel; a push into a full buffer is
// still accepted when the same cycle pops.
module vc_fifo
  import chiplet_types_pkg::*;
#(
  parameter  int unsigned BUFFER_DEPTH = 8,
  localparam int unsigned PTR_W        = $clog2(BUFFER_DEPTH),
  localparam int unsigned CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  fifo_entry_t       push_data,
  input  logic              pop,
  output fifo_entry_t       head_c,
  output logic [CNT_W-1:0]  count,
  output logic              empty_c,
  output logic              drop_c
);

  fifo_entry_t      mem [BUFFER_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full_c;
  logic             pop_ok_c;
  logic             accept_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c   = (count == CNT_W'(BUFFER_DEPTH));
  assign empty_c  = (count == '0);
  assign pop_ok_c = pop && !empty_c;
  assign accept_c = push && (!full_c || pop_ok_c);
  assign drop_c   = push && !accept_c;
  assign head_c   = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept_c) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (accept_c && !pop_ok_c) begin
        count <= count + CNT_W'(1);
      end else if (!accept_c && pop_ok_c) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vc_input_port.sv
// Router input port: per-VC buffering, head-flit route compute handshake,
// switch request/grant and registered flit/credit return.
module vc_input_port
  import chiplet_types_pkg::*;
#(
  parameter  int unsigned NUM_VCS      = 2,
  parameter  int unsigned BUFFER_DEPTH = 8,
  parameter  int unsigned NUM_OUTPORTS = 4,
  localparam int unsigned VC_BITS      = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  in_valid,
  input  flit_t                                 in_flit,
  input  logic [VC_BITS-1:0]                    in_vc,
  input  logic                                  in_last,
  output logic [NUM_VCS-1:0]                    buffer_available,
  output logic                                  rc_valid,
  output logic [VC_BITS-1:0]                    rc_vc,
  output flit_t                                 rc_flit,
  input  logic                                  rc_done,
  input  logic [NUM_OUTPORTS-1:0]               rc_outport,
  output logic [NUM_VCS-1:0]                    sa_req,
  output logic [NUM_VCS-1:0][NUM_OUTPORTS-1:0]  sa_outport,
  input  logic [NUM_VCS-1:0]                    sa_grant,
  output logic                                  out_valid,
  output flit_t                                 out_flit,
  output logic [VC_BITS-1:0]                    out_vc,
  output logic                                  credit_valid,
  output logic [VC_BITS-1:0]                    credit_vc,
  output logic                                  overflow
);

  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

  fifo_entry_t                           in_entry_c;
  fifo_entry_t                           head_c [NUM_VCS];
  logic [CNT_W-1:0]                      count [NUM_VCS];
  logic [NUM_VCS-1:0]                    empty_c;
  logic [NUM_VCS-1:0]                    drop_c;
  logic [NUM_VCS-1:0]                    push_c;
  logic [NUM_VCS-1:0]                    pop_c;
  logic                                  pop_any_c;
  logic [VC_BITS-1:0]                    pop_sel_c;
  fifo_entry_t                           pop_entry_c;
  vc_state_t                             state_q [NUM_VCS];
  vc_state_t                             state_d [NUM_VCS];
  logic [NUM_VCS-1:0][NUM_OUTPORTS-1:0]  outport_d;

  assign in_entry_c = '{last: in_last, flit: in_flit};

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
    assign push_c[g]           = in_valid && (in_vc == VC_BITS'(g));
    assign buffer_available[g] = (count[g] < CNT_W'(BUFFER_DEPTH));
    assign sa_req[g]           = (state_q[g] == ACTIVE) && !empty_c[g];

    vc_fifo #(
      .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (push_c[g]),
      .push_data (in_entry_c),
      .pop       (pop_c[g]),
      .head_c    (head_c[g]),
      .count     (count[g]),
      .empty_c   (empty_c[g]),
      .drop_c    (drop_c[g])
    );
  end

  // Route compute presentation: lowest-index VC waiting in ROUTING wins.
  always_comb begin
    rc_valid = 1'b0;
    rc_vc    = '0;
    rc_flit  = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (!rc_valid && (state_q[v] == ROUTING)) begin
        rc_valid = 1'b1;
        rc_vc    = VC_BITS'(v);
        rc_flit  = head_c[v].flit;
      end
    end
  end

  // Single pop per cycle: lowest-index VC that both requests and is granted.
  always_comb begin
    pop_any_c   = 1'b0;
    pop_sel_c   = '0;
    pop_entry_c = '0;
    pop_c       = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (!pop_any_c && sa_grant[v] && sa_req[v]) begin
        pop_any_c   = 1'b1;
        pop_sel_c   = VC_BITS'(v);
        pop_entry_c = head_c[v];
        pop_c[v]    = 1'b1;
      end
    end
  end

  // Per-VC packet FSM next state and latched route.
  always_comb begin
    state_d   = state_q;
    outport_d = sa_outport;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      case (state_q[v])
        IDLE: begin
          if (!empty_c[v]) begin
            state_d[v] = ROUTING;
          end
        end
        ROUTING: begin
          if (rc_done && rc_valid && (rc_vc == VC_BITS'(v))) begin
            state_d[v]   = ACTIVE;
            outport_d[v] = rc_outport;
          end
        end
        ACTIVE: begin
          if (pop_c[v] && pop_entry_c.last) begin
            state_d[v]   = IDLE;
            outport_d[v] = '0;
          end
        end
        default: begin
          state_d[v]   = IDLE;
          outport_d[v] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= '{default: IDLE};
      sa_outport <= '0;
    end else begin
      state_q    <= state_d;
      sa_outport <= outport_d;
    end
  end

  // Forwarded flit and upstream credit are one-cycle pulses after the pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid    <= 1'b0;
      out_flit     <= '0;
      out_vc       <= '0;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      overflow     <= 1'b0;
    end else begin
      out_valid    <= pop_any_c;
      out_flit     <= pop_any_c ? pop_entry_c.flit : '0;
      out_vc       <= pop_sel_c;
      credit_valid <= pop_any_c;
      credit_vc    <= pop_sel_c;
      overflow     <= overflow | (|drop_c);
    end
  end

endmodule

// File: tb/tb_vc_input_port.sv
// Self-checking bench for vc_input_port: directed scenarios plus a randomized
// run against a queue-based packet model.
module tb_vc_input_port;
  import chiplet_types_pkg::*;

  localparam int unsigned NUM_VCS = 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned NOP     = 4;
  localparam int unsigned VC_BITS = 1;

  logic                          clk;
  logic                          n_rst;
  logic                          in_valid;
  flit_t                         in_flit;
  logic [VC_BITS-1:0]            in_vc;
  logic                          in_last;
  logic [NUM_VCS-1:0]            buffer_available;
  logic                          rc_valid;
  logic [VC_BITS-1:0]            rc_vc;
  flit_t                         rc_flit;
  logic                          rc_done;
  logic [NOP-1:0]                rc_outport;
  logic [NUM_VCS-1:0]            sa_req;
  logic [NUM_VCS-1:0][NOP-1:0]   sa_outport;
  logic [NUM_VCS-1:0]            sa_grant;
  logic                          out_valid;
  flit_t                         out_flit;
  logic [VC_BITS-1:0]            out_vc;
  logic                          credit_valid;
  logic [VC_BITS-1:0]            credit_vc;
  logic                          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  vc_input_port #(
    .NUM_VCS      (NUM_VCS),
    .BUFFER_DEPTH (DEPTH),
    .NUM_OUTPORTS (NOP)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .in_valid         (in_valid),
    .in_flit          (in_flit),
    .in_vc            (in_vc),
    .in_last          (in_last),
    .buffer_available (buffer_available),
    .rc_valid         (rc_valid),
    .rc_vc            (rc_vc),
    .rc_flit          (rc_flit),
    .rc_done          (rc_done),
    .rc_outport       (rc_outport),
    .sa_req           (sa_req),
    .sa_outport       (sa_outport),
    .sa_grant         (sa_grant),
    .out_valid        (out_valid),
    .out_flit         (out_flit),
    .out_vc           (out_vc),
    .credit_valid     (credit_valid),
    .credit_vc        (credit_vc),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic flit_t rand_flit();
    flit_t f;
    f.dst     = node_id_t'($urandom);
    f.src     = node_id_t'($urandom);
    f.pkt_id  = pkt_id_t'($urandom);
    f.payload = 16'($urandom);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_flit    = '0;
    in_vc      = '0;
    in_last    = 1'b0;
    rc_done    = 1'b0;
    rc_outport = '0;
    sa_grant   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_rst = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
  endtask

  task automatic push_one(input int vc, input flit_t f, input logic last);
    in_valid = 1'b1;
    in_vc    = VC_BITS'(vc);
    in_flit  = f;
    in_last  = last;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    n_rst = 1'b0;
    #3;
    if (buffer_available !== 2'b11) begin n_fail++; $display("FAIL reset_buffer_available: got %b expected 11", buffer_available); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++;
    if (credit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_credit_valid: got %b expected 0", credit_valid); end
    n_checks++;
    if (rc_valid !== 1'b0 || sa_req !== 2'b00 || sa_outport !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: rc_valid=%b sa_req=%b sa_outport=%h expected 0/00/00", rc_valid, sa_req, sa_outport);
    end
    n_checks++;
    tick();
    n_rst = 1'b1;
  endtask

  task automatic test_three_flit();
    flit_t f [3];
    int k;
    do_reset();
    for (int i = 0; i < 3; i++) f[i] = rand_flit();
    for (int i = 0; i < 3; i++) push_one(0, f[i], (i == 2));
    if (rc_valid !== 1'b1 || rc_vc !== 1'b0) begin n_fail++; $display("FAIL three_rc_present: rc_valid=%b rc_vc=%0d expected 1/0", rc_valid, rc_vc); end
    n_checks++;
    if (rc_flit !== f[0]) begin n_fail++; $display("FAIL three_rc_flit: got %h expected %h", rc_flit, f[0]); end
    n_checks++;
    rc_done = 1'b1; rc_outport = 4'b0010;
    tick();
    rc_done = 1'b0;
    if (sa_outport[0] !== 4'b0010 || sa_req !== 2'b01) begin
      n_fail++; $display("FAIL three_route_latched: sa_outport0=%b sa_req=%b expected 0010/01", sa_outport[0], sa_req);
    end
    n_checks++;
    sa_grant = 2'b01;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        if (k >= 3 || out_flit !== f[k] || out_vc !== 1'b0 || credit_valid !== 1'b1 || credit_vc !== 1'b0) begin
          n_fail++; $display("FAIL three_out_%0d: flit=%h vc=%0d credit=%b/%0d expected %h on vc0 with credit", k, out_flit, out_vc, credit_valid, credit_vc, (k < 3) ? f[k] : '0);
        end
        n_checks++;
        k++;
      end
    end
    sa_grant = '0;
    if (k !== 3) begin n_fail++; $display("FAIL three_out_count: got %0d expected 3", k); end
    n_checks++;
    if (sa_outport[0] !== 4'b0000 || sa_req !== 2'b00 || rc_valid !== 1'b0) begin
      n_fail++; $display("FAIL three_back_idle: sa_outport0=%b sa_req=%b rc_valid=%b expected 0000/00/0", sa_outport[0], sa_req, rc_valid);
    end
    n_checks++;
  endtask

  task automatic test_overflow();
    flit_t f [9];
    int k;
    do_reset();
    for (int i = 0; i < 9; i++) f[i] = rand_flit();
    for (int i = 0; i < 9; i++) begin
      push_one(1, f[i], 1'b0);
      if (buffer_available !== {(i < 7), 1'b1}) begin
        n_fail++; $display("FAIL ovf_avail_after_%0d: got %b expected %b", i + 1, buffer_available, {(i < 7), 1'b1});
      end
      n_checks++;
      if (overflow !== (i == 8)) begin n_fail++; $display("FAIL ovf_flag_after_%0d: got %b expected %b", i + 1, overflow, (i == 8)); end
      n_checks++;
    end
    if (rc_valid !== 1'b1 || rc_vc !== 1'b1) begin n_fail++; $display("FAIL ovf_rc: rc_valid=%b rc_vc=%0d expected 1/1", rc_valid, rc_vc); end
    n_checks++;
    rc_done = 1'b1; rc_outport = 4'b0100;
    tick();
    rc_done = 1'b0;
    sa_grant = 2'b10;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        if (k >= 8 || out_flit !== f[k] || out_vc !== 1'b1 || credit_vc !== 1'b1) begin
          n_fail++; $display("FAIL ovf_drain_%0d: flit=%h vc=%0d credit_vc=%0d expected %h on vc1", k, out_flit, out_vc, credit_vc, (k < 8) ? f[k] : '0);
        end
        n_checks++;
        k++;
      end
    end
    sa_grant = '0;
    if (k !== 8) begin n_fail++; $display("FAIL ovf_stored_count: got %0d expected 8", k); end
    n_checks++;
    if (overflow !== 1'b1 || buffer_available !== 2'b11) begin
      n_fail++; $display("FAIL ovf_sticky: overflow=%b avail=%b expected 1/11", overflow, buffer_available);
    end
    n_checks++;
  endtask

  task automatic test_rc_priority();
    flit_t a, b;
    do_reset();
    a = rand_flit();
    b = rand_flit();
    push_one(0, a, 1'b1);
    push_one(1, b, 1'b1);
    tick();
    if (rc_valid !== 1'b1 || rc_vc !== 1'b0 || rc_flit !== a) begin
      n_fail++; $display("FAIL prio_first: rc_valid=%b rc_vc=%0d flit=%h expected 1/0/%h", rc_valid, rc_vc, rc_flit, a);
    end
    n_checks++;
    rc_done = 1'b1; rc_outport = 4'b0001;
    tick();
    if (rc_valid !== 1'b1 || rc_vc !== 1'b1 || rc_flit !== b) begin
      n_fail++; $display("FAIL prio_second: rc_valid=%b rc_vc=%0d flit=%h expected 1/1/%h", rc_valid, rc_vc, rc_flit, b);
    end
    n_checks++;
    rc_outport = 4'b1000;
    tick();
    rc_done = 1'b0;
    if (rc_valid !== 1'b0 || sa_outport !== {4'b1000, 4'b0001} || sa_req !== 2'b11) begin
      n_fail++; $display("FAIL prio_routes: rc_valid=%b sa_outport=%h sa_req=%b expected 0/81/11", rc_valid, sa_outport, sa_req);
    end
    n_checks++;
    sa_grant = 2'b11;
    tick();
    if (out_valid !== 1'b1 || out_vc !== 1'b0 || out_flit !== a) begin
      n_fail++; $display("FAIL multigrant_low: valid=%b vc=%0d flit=%h expected 1/0/%h", out_valid, out_vc, out_flit, a);
    end
    n_checks++;
    tick();
    sa_grant = '0;
    if (out_valid !== 1'b1 || out_vc !== 1'b1 || out_flit !== b) begin
      n_fail++; $display("FAIL multigrant_next: valid=%b vc=%0d flit=%h expected 1/1/%h", out_valid, out_vc, out_flit, b);
    end
    n_checks++;
    tick();
    if (out_valid !== 1'b0 || sa_outport !== '0) begin
      n_fail++; $display("FAIL single_flit_idle: valid=%b sa_outport=%h expected 0/00", out_valid, sa_outport);
    end
    n_checks++;
  endtask

  task automatic test_full_push_pop();
    flit_t g [9];
    int k;
    do_reset();
    for (int i = 0; i < 9; i++) g[i] = rand_flit();
    for (int i = 0; i < 8; i++) push_one(0, g[i], 1'b0);
    if (buffer_available[0] !== 1'b0) begin n_fail++; $display("FAIL fpp_full: avail0=%b expected 0", buffer_available[0]); end
    n_checks++;
    rc_done = 1'b1; rc_outport = 4'b0010;
    tick();
    rc_done = 1'b0;
    in_valid = 1'b1; in_vc = 1'b0; in_flit = g[8]; in_last = 1'b1;
    sa_grant = 2'b01;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    if (out_valid !== 1'b1 || out_flit !== g[0]) begin
      n_fail++; $display("FAIL fpp_pop: valid=%b flit=%h expected 1/%h", out_valid, out_flit, g[0]);
    end
    n_checks++;
    if (overflow !== 1'b0 || buffer_available[0] !== 1'b0) begin
      n_fail++; $display("FAIL fpp_push_accepted: overflow=%b avail0=%b expected 0/0", overflow, buffer_available[0]);
    end
    n_checks++;
    k = 1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        if (k >= 9 || out_flit !== g[k]) begin
          n_fail++; $display("FAIL fpp_drain_%0d: flit=%h expected %h", k, out_flit, (k < 9) ? g[k] : '0);
        end
        n_checks++;
        k++;
      end
    end
    sa_grant = '0;
    if (k !== 9 || sa_outport[0] !== 4'b0000) begin
      n_fail++; $display("FAIL fpp_total: flits=%0d sa_outport0=%b expected 9/0000", k, sa_outport[0]);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(0, rand_flit(), 1'b0);
    rc_done = 1'b1; rc_outport = 4'b0100;
    tick();
    rc_done = 1'b0;
    sa_grant = 2'b01;
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    if (out_valid !== 1'b0 || credit_valid !== 1'b0 || out_flit !== '0 || out_vc !== 1'b0 || credit_vc !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: valid=%b credit=%b flit=%h expected all zero", out_valid, credit_valid, out_flit);
    end
    n_checks++;
    if (buffer_available !== 2'b11 || sa_req !== 2'b00 || rc_valid !== 1'b0 || sa_outport !== '0) begin
      n_fail++; $display("FAIL midrst_state: avail=%b sa_req=%b rc_valid=%b sa_outport=%h expected 11/00/0/00", buffer_available, sa_req, rc_valid, sa_outport);
    end
    n_checks++;
    repeat (2) tick();
    n_rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid !== 1'b0 || credit_valid !== 1'b0 || rc_valid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_discard_%0d: valid=%b credit=%b rc_valid=%b expected 0/0/0", c, out_valid, credit_valid, rc_valid);
      end
      n_checks++;
    end
    sa_grant = '0;
  endtask

  task automatic test_random();
    fifo_entry_t q [NUM_VCS][$];
    bit          routed [NUM_VCS];
    bit          pend_prev [NUM_VCS];
    bit          pend_now [NUM_VCS];
    logic [NOP-1:0] port [NUM_VCS];
    bit          ovf;
    logic        exp_rc_valid;
    int          exp_rc_vc;
    logic [NUM_VCS-1:0] exp_req, exp_avail;
    logic [NUM_VCS-1:0][NOP-1:0] exp_outport;
    int          pop_v;
    fifo_entry_t e;
    bit          accept;
    bit          fill_phase;

    do_reset();
    ovf = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      routed[v] = 1'b0; pend_prev[v] = 1'b0; port[v] = '0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_rc_valid = 1'b0;
      exp_rc_vc    = 0;
      for (int v = 0; v < NUM_VCS; v++) begin
        if (!exp_rc_valid && !routed[v] && pend_prev[v]) begin
          exp_rc_valid = 1'b1;
          exp_rc_vc    = v;
        end
        exp_req[v]     = routed[v] && (q[v].size() > 0);
        exp_avail[v]   = (q[v].size() < DEPTH);
        exp_outport[v] = routed[v] ? port[v] : '0;
      end

      if (sa_req !== exp_req || buffer_available !== exp_avail || sa_outport !== exp_outport) begin
        n_fail++; $display("FAIL rand_status cyc %0d: sa_req=%b avail=%b outport=%h expected %b/%b/%h", cyc, sa_req, buffer_available, sa_outport, exp_req, exp_avail, exp_outport);
      end
      n_checks++;
      if (rc_valid !== exp_rc_valid || (exp_rc_valid && (rc_vc !== VC_BITS'(exp_rc_vc) || rc_flit !== q[exp_rc_vc][0].flit))) begin
        n_fail++; $display("FAIL rand_rc cyc %0d: rc_valid=%b rc_vc=%0d expected %b/%0d", cyc, rc_valid, rc_vc, exp_rc_valid, exp_rc_vc);
      end
      n_checks++;

      fill_phase = ((cyc / 250) % 2) == 1;
      in_valid   = ($urandom_range(0, 99) < 60);
      in_vc      = VC_BITS'($urandom_range(0, NUM_VCS - 1));
      in_flit    = rand_flit();
      in_last    = ($urandom_range(0, 2) == 0);
      rc_done    = exp_rc_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rc_outport = NOP'(1 << $urandom_range(0, NOP - 1));
      sa_grant   = fill_phase ? (($urandom_range(0, 5) == 0) ? NUM_VCS'($urandom) : '0) : NUM_VCS'($urandom);

      pop_v = -1;
      for (int v = 0; v < NUM_VCS; v++) begin
        if (pop_v < 0 && sa_grant[v] && exp_req[v]) pop_v = v;
        pend_now[v] = !routed[v] && (q[v].size() > 0);
      end
      accept = in_valid && ((q[int'(in_vc)].size() < DEPTH) || (pop_v == int'(in_vc)));
      e = '0;
      if (pop_v >= 0) begin
        e = q[pop_v].pop_front();
        if (e.last) begin
          routed[pop_v] = 1'b0;
          port[pop_v]   = '0;
        end
      end
      if (rc_done && exp_rc_valid) begin
        routed[exp_rc_vc] = 1'b1;
        port[exp_rc_vc]   = rc_outport;
      end
      if (accept) q[int'(in_vc)].push_back('{last: in_last, flit: in_flit});
      else if (in_valid) ovf = 1'b1;
      for (int v = 0; v < NUM_VCS; v++) pend_prev[v] = pend_now[v];

      tick();

      if (out_valid !== (pop_v >= 0) || credit_valid !== (pop_v >= 0)) begin
        n_fail++; $display("FAIL rand_out_valid cyc %0d: out_valid=%b credit_valid=%b expected %b", cyc, out_valid, credit_valid, (pop_v >= 0));
      end
      n_checks++;
      if (pop_v >= 0) begin
        if (out_flit !== e.flit || out_vc !== VC_BITS'(pop_v) || credit_vc !== VC_BITS'(pop_v)) begin
          n_fail++; $display("FAIL rand_out_data cyc %0d: flit=%h vc=%0d credit_vc=%0d expected %h/%0d", cyc, out_flit, out_vc, credit_vc, e.flit, pop_v);
        end
        n_checks++;
      end
      if (overflow !== ovf) begin n_fail++; $display("FAIL rand_overflow cyc %0d: got %b expected %b", cyc, overflow, ovf); end
      n_checks++;
    end
    idle_inputs();
  endtask

  initial begin
    n_rst = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_three_flit();
    test_overflow();
    test_rc_priority();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_input_port.md
VC_INPUT_PORT -- requirements
Module: vc_input_port

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2, virtual channels per input port (>=1).
REQ-002 SHALL have parameter BUFFER_DEPTH, default 8, flits per VC FIFO (power of two, >=2).
REQ-003 SHALL have parameter NUM_OUTPORTS, default 4, switch output ports.
REQ-004 SHALL have ports:
  clk  in  1  clock, all state on posedge.
  n_rst  in  1  reset, asynchronous, active-low.
  in_valid  in  1  flit present on in_flit this cycle.
  in_flit  in  flit_t  incoming flit.
  in_vc  in  VC_BITS  target VC of in_flit.
  in_last  in  1  in_flit is the packet tail.
  buffer_available  out  NUM_VCS  bit v = VC v count < BUFFER_DEPTH.
  rc_valid  out  1  head flit presented for route compute.
  rc_vc  out  VC_BITS  VC owning the presented head.
  rc_flit  out  flit_t  head flit of rc_vc.
  rc_done  in  1  route compute result valid for rc_vc.
  rc_outport  in  NUM_OUTPORTS  one-hot output port chosen.
  sa_req  out  NUM_VCS  bit v = VC v requests the switch.
  sa_outport  out  NUM_VCS x NUM_OUTPORTS  latched route per VC.
  sa_grant  in  NUM_VCS  switch allocator grant.
  out_valid  out  1  out_flit valid.
  out_flit  out  flit_t  flit forwarded to crossbar.
  out_vc  out  VC_BITS  VC out_flit left.
  credit_valid  out  1  one slot freed upstream.
  credit_vc  out  VC_BITS  VC of freed slot.
  overflow  out  1  sticky: write to full VC.

Function
REQ-005 SHALL keep one circular FIFO per VC: rd/wr pointers $clog2(BUFFER_DEPTH) bits wrapping DEPTH-1 -> 0; count $clog2(BUFFER_DEPTH+1) bits.
REQ-006 SHALL write in_flit and in_last to FIFO in_vc on in_valid when count < DEPTH; flit readable at head next cycle.
REQ-007 SHALL drop a write to a full VC and set overflow, held until reset; other VCs unaffected.
REQ-008 SHALL keep count unchanged on simultaneous push and pop to one VC; a pop from full plus push same cycle SHALL be accepted.
REQ-009 SHALL run per-VC FSM IDLE -> ROUTING -> ACTIVE.
REQ-010 IDLE: FIFO non-empty -> ROUTING (head flit is packet head).
REQ-011 ROUTING: rc_valid arbitration among ROUTING VCs, fixed priority lowest index; rc_done while rc_vc = v -> latch rc_outport into sa_outport[v], go ACTIVE.
REQ-012 ACTIVE: sa_req[v] = FIFO non-empty; granted pop of flit with last=1 -> IDLE, sa_outport[v] cleared.
REQ-013 SHALL pop at most one flit per cycle; multi-hot sa_grant honours lowest-index requesting bit; grant to non-requesting VC ignored.
REQ-014 SHALL register popped flit: out_valid, out_flit, out_vc, credit_valid, credit_vc asserted cycle after grant, for exactly one cycle.
REQ-015 SHALL deassert rc_valid whenever no VC in ROUTING; rc_flit = '0 then.
REQ-016 Single-flit packet (head with last=1) SHALL pass ROUTING, ACTIVE, return to IDLE after its pop.

Reset
REQ-017 On n_rst low, SHALL asynchronously clear pointers, counts, FIFO storage, FSMs to IDLE, sa_outport, overflow, out_valid, out_flit, out_vc, credit_valid, credit_vc to 0.
REQ-018 After reset buffer_available SHALL be all ones; reset mid-packet SHALL discard all buffered flits without credit pulses.

Structure
REQ-019 flit_t, pkt_id_t, node_id_t, vc_state_t (IDLE/ROUTING/ACTIVE) SHALL live in chiplet_types_pkg; VC_BITS = max(1,$clog2(NUM_VCS)) local.
REQ-020 Per-VC storage SHALL be sub-module vc_fifo (BUFFER_DEPTH, flit_t plus last bit), instantiated NUM_VCS times.

Verification
REQ-021 Reset, DEPTH=8: buffer_available=2'b11, out_valid=0, overflow=0.
REQ-022 3-flit packet on VC0, rc_done rc_outport=4'b0010, sa_grant[0] each cycle -> three out_flits in order, three credit pulses credit_vc=0, FSM IDLE.
REQ-023 9 writes to VC1 without grant -> buffer_available[1]=0 after 8th, overflow=1 after 9th, VC1 count=8.
REQ-024 Both VCs ROUTING same cycle -> rc_vc=0 first, rc_vc=1 after VC0 rc_done.
REQ-025 Full VC0, push and grant same cycle -> both accepted, count stays 8, no overflow.
REQ-026 Assert n_rst with 4 flits buffered -> outputs zero, no credit_valid, buffer_available=all ones.
